// File: rtl/aftab_seq_multiplier.sv
// ---------------------------------------------------------------------------
// aftab_seq_multiplier
//   Iterative shift-add multiplier for the AFTAB datapath. Two size-bit
//   operands, each with its own signedness flag (covers MUL/MULH/MULHSU/MULHU),
//   are multiplied as magnitudes over a multi-cycle run. The sign is applied
//   once at the end and the full 2*size-bit product is held on result.
//   result feeds the datapath result registers' in bus; done feeds their ldR.
//
// Parameters
//   size      operand width; the product is 2*size bits wide
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous clear: abort run, zero result, back to IDLE
//   start     in   request, sampled only in IDLE
//   signed_a  in   a is two's complement
//   signed_b  in   b is two's complement
//   a, b      in   operands, captured with an accepted start
//   busy      out  high in LOAD and MULT
//   done      out  one-cycle pulse while in DONE; result is valid
//   result    out  product, held until the next DONE, clr or rst
//
// Build option
//   AFTAB_MULT_EARLY_EXIT_EN  when defined, the run stops as soon as the
//   remaining multiplier bits are all zero (and skips MULT when |b| == 0).
//   Results are identical; only the latency shrinks.
// ---------------------------------------------------------------------------
module aftab_seq_multiplier #(
  parameter int size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                start,
  input  logic                signed_a,
  input  logic                signed_b,
  input  logic [size-1:0]     a,
  input  logic [size-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [2*size-1:0]   result
);

  localparam int CNT_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(size - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [size-1:0]   a_q, a_d;
  logic [size-1:0]   b_q, b_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              neg_q, neg_d;
  logic [2*size-1:0] mcand_q, mcand_d;
  logic [size-1:0]   mplier_q, mplier_d;
  logic [2*size-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2*size-1:0] result_q, result_d;

  // Magnitude of a possibly-signed operand. -2^(size-1) maps to 2^(size-1),
  // which still fits in size unsigned bits.
  function automatic logic [size-1:0] magnitude(input logic [size-1:0] x,
                                                 input logic is_signed);
    if (is_signed && x[size-1]) return -x;
    return x;
  endfunction

  // Re-apply the product sign, modulo 2^(2*size).
  function automatic logic [2*size-1:0] apply_sign(input logic [2*size-1:0] m,
                                                    input logic neg);
    return neg ? -m : m;
  endfunction

  logic [size-1:0]   mag_a, mag_b;
  logic [2*size-1:0] acc_sum;
  logic [size-1:0]   mplier_shr;
  logic              mult_last;
  logic              load_skip;

  assign mag_a      = magnitude(a_q, sa_q);
  assign mag_b      = magnitude(b_q, sb_q);
  assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : {2*size{1'b0}});
  assign mplier_shr = mplier_q >> 1;

`ifdef AFTAB_MULT_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain; a zero |b| never enters MULT.
  assign mult_last = (count_q == LAST_CNT) || (mplier_shr == '0);
  assign load_skip = (mag_b == '0);
`else
  assign mult_last = (count_q == LAST_CNT);
  assign load_skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = LOAD;
        LOAD:    state_d = load_skip ? DONE : MULT;
        MULT:    if (mult_last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == LOAD) || (state_q == MULT);
    done = (state_q == DONE);
  end

  assign result = result_q;

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    if (clr) begin
      result_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d  = a;
            b_d  = b;
            sa_d = signed_a;
            sb_d = signed_b;
          end
        end
        LOAD: begin
          mcand_d  = {{size{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = (sa_q & a_q[size-1]) ^ (sb_q & b_q[size-1]);
          acc_d    = '0;
          count_d  = '0;
          if (load_skip) result_d = '0;
        end
        MULT: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shr;
          count_d  = count_q + CNT_W'(1);
          // Result is taken from this cycle's sum so the last partial product counts.
          if (mult_last) result_d = apply_sign(acc_sum, neg_q);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

endmodule
